// File: rtl/hex_display_scanner_pkg.sv
// -----------------------------------------------------------------------------
// hex_display_pkg
// Shared types and constants for the four-digit hex display scanner.
//   NUM_DIGITS      : number of multiplexed digits
//   digit_idx_t     : 2-bit active-digit index
//   state_t         : scanner FSM states (IDLE, SCAN)
//   ANODE_Dn        : one-hot active-high anode patterns
//   anode_onehot()  : index -> anode pattern
//   msnz_digit()    : index of the most-significant non-zero nibble
//                     (only built when HEX_LZB_EN is defined)
// -----------------------------------------------------------------------------
package hex_display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [3:0] ANODE_D0 = 4'b0001;
    localparam logic [3:0] ANODE_D1 = 4'b0010;
    localparam logic [3:0] ANODE_D2 = 4'b0100;
    localparam logic [3:0] ANODE_D3 = 4'b1000;

    function automatic logic [3:0] anode_onehot(input digit_idx_t idx);
        logic [3:0] a;
        case (idx)
            2'd0:    a = ANODE_D0;
            2'd1:    a = ANODE_D1;
            2'd2:    a = ANODE_D2;
            default: a = ANODE_D3;
        endcase
        return a;
    endfunction

`ifdef HEX_LZB_EN
    // Returns 0 for an all-zero value, so digit0 is never auto-blanked.
    function automatic digit_idx_t msnz_digit(input logic [15:0] v);
        digit_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i*4 +: 4] != 4'h0) idx = digit_idx_t'(i);
        end
        return idx;
    endfunction
`endif

endpackage

// File: rtl/hex_display_scanner_if.sv
// -----------------------------------------------------------------------------
// hex_display_scanner_if
// Bus between a host and the hex display scanner.
//   Value[15:0]     host -> scanner  four hex nibbles, digit0 = Value[3:0]
//   Load            host -> scanner  capture strobe for the shadow register
//   Enable          host -> scanner  scan enable
//   DigitBlank[3:0] host -> scanner  per-digit forced blank
//   Hex[3:0]        scanner -> host  nibble of the active digit
//   DP              scanner -> host  blank flag (1 = all segments off)
//   Anode[3:0]      scanner -> host  one-hot active-high digit enable
//   Loaded          scanner -> host  one-cycle capture acknowledge
// -----------------------------------------------------------------------------
interface hex_display_scanner_if;

    logic [15:0] Value;
    logic        Load;
    logic        Enable;
    logic [3:0]  DigitBlank;
    logic [3:0]  Hex;
    logic        DP;
    logic [3:0]  Anode;
    logic        Loaded;

    modport master (
        output Value, Load, Enable, DigitBlank,
        input  Hex, DP, Anode, Loaded
    );

    modport slave (
        input  Value, Load, Enable, DigitBlank,
        output Hex, DP, Anode, Loaded
    );

endinterface

// File: rtl/hex_display_scanner_prescaler.sv
// -----------------------------------------------------------------------------
// refresh_prescaler
// Counts 0..CLK_DIV-1 while run is high and holds its count otherwise.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   run   : count enable
//   tick  : high on the cycle the count equals CLK_DIV-1 while running
// Parameter CLK_DIV (>= 2): clock cycles per tick.
// -----------------------------------------------------------------------------
module refresh_prescaler #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int                CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_count;

    assign tick = run && (r_count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (run) begin
            if (r_count == LAST) r_count <= '0;
            else                 r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// -----------------------------------------------------------------------------
// hex_display_scanner
// Multiplexes a 16-bit shadow value onto a four-digit 7-segment display,
// advancing one digit every CLK_DIV clocks while enabled.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : hex_display_scanner_if.slave (Value, Load, Enable, DigitBlank in;
//           Hex, DP, Anode, Loaded out)
// Parameter CLK_DIV (>= 2): clock cycles per digit.
// Optional macro HEX_LZB_EN: blank digits above the most-significant non-zero
// shadow nibble (digit0 always shown).
// -----------------------------------------------------------------------------
module hex_display_scanner #(
    parameter int CLK_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hex_display_scanner_if.slave  bus
);

    import hex_display_pkg::*;

    state_t     r_state;
    state_t     w_state_nxt;
    digit_idx_t r_index;
    logic [15:0] r_shadow;
    logic [3:0]  r_blank;
    logic        r_loaded;
    logic        w_run;
    logic        w_tick;

    assign w_run = (r_state == SCAN);

    refresh_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.Enable)  w_state_nxt = SCAN;
            SCAN:    if (!bus.Enable) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // DigitBlank is registered so that every output decodes from flops only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index  <= '0;
            r_shadow <= '0;
            r_blank  <= '0;
            r_loaded <= 1'b0;
        end else begin
            if (w_tick)   r_index  <= digit_idx_t'(r_index + 2'd1);
            if (bus.Load) r_shadow <= bus.Value;
            r_loaded <= bus.Load;
            r_blank  <= bus.DigitBlank;
        end
    end

    always_comb begin
        bus.Hex   = 4'h0;
        bus.DP    = 1'b1;
        bus.Anode = 4'b0000;
        if (r_state == SCAN) begin
            bus.Anode = anode_onehot(r_index);
            bus.Hex   = r_shadow[{r_index, 2'b00} +: 4];
`ifdef HEX_LZB_EN
            bus.DP    = r_blank[r_index] | (r_index > msnz_digit(r_shadow));
`else
            bus.DP    = r_blank[r_index];
`endif
        end
    end

    assign bus.Loaded = r_loaded;

endmodule

// File: tb/tb_hex_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_hex_display_scanner
// Directed testbench for hex_display_scanner with CLK_DIV = 4.
// -----------------------------------------------------------------------------
module tb_hex_display_scanner;

    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks  = 0;
    int   passed  = 0;
    int   edge_no = 0;

    hex_display_scanner_if bus();

    hex_display_scanner #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    function automatic logic [3:0] onehot(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return one << d;
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        return v[d*4 +: 4];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Enable = 1'b0;
        bus.Load = 1'b0;
        bus.Value = 16'hBEEF;
        bus.DigitBlank = 4'hF;
        #2;
        checks++;
        if ({bus.Anode, bus.DP, bus.Hex, bus.Loaded} !== {4'b0000, 1'b1, 4'h0, 1'b0})
            $display("FAIL reset_out: got %b required %b",
                     {bus.Anode, bus.DP, bus.Hex, bus.Loaded}, {4'b0000, 1'b1, 4'h0, 1'b0});
        else passed++;
        step();
        step();
        rst_n = 1'b1;
        bus.DigitBlank = 4'h0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({bus.Anode, bus.DP, bus.Hex, bus.Loaded} !== {4'b0000, 1'b1, 4'h0, 1'b0})
                $display("FAIL idle_out[%0d]: got %b required %b", i,
                         {bus.Anode, bus.DP, bus.Hex, bus.Loaded}, {4'b0000, 1'b1, 4'h0, 1'b0});
            else passed++;
        end
    endtask

    task automatic test_scan();
        int d;
        bus.Load = 1'b1;
        bus.Value = 16'hA3F1;
        step();
        checks++;
        if ({bus.Loaded, bus.Anode} !== {1'b1, 4'b0000})
            $display("FAIL load_in_idle: got %b required %b", {bus.Loaded, bus.Anode}, 5'b10000);
        else passed++;
        bus.Load = 1'b0;
        bus.Enable = 1'b1;
        bus.Value = 16'h5555;
        step();
        edge_no = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 6) bus.Value = 16'h0F0F;
            d = (edge_no / 4) % 4;
            checks++;
            if ({bus.Anode, bus.Hex, bus.DP, bus.Loaded} !== {onehot(d), nib(16'hA3F1, d), 1'b0, 1'b0})
                $display("FAIL scan_seq[%0d]: got %b required %b", k,
                         {bus.Anode, bus.Hex, bus.DP, bus.Loaded},
                         {onehot(d), nib(16'hA3F1, d), 1'b0, 1'b0});
            else passed++;
            step();
        end
    endtask

    task automatic test_load_tick();
        step();
        step();
        step();
        checks++;
        if ({bus.Anode, bus.Hex, bus.Loaded} !== {4'b0010, 4'hF, 1'b0})
            $display("FAIL pre_load_digit1: got %b required %b",
                     {bus.Anode, bus.Hex, bus.Loaded}, {4'b0010, 4'hF, 1'b0});
        else passed++;
        bus.Load = 1'b1;
        bus.Value = 16'h1234;
        step();
        checks++;
        if ({bus.Anode, bus.Hex, bus.Loaded} !== {4'b0100, 4'h2, 1'b1})
            $display("FAIL load_tick_digit2: got %b required %b",
                     {bus.Anode, bus.Hex, bus.Loaded}, {4'b0100, 4'h2, 1'b1});
        else passed++;
        bus.Load = 1'b0;
        step();
        checks++;
        if ({bus.Anode, bus.Hex, bus.Loaded} !== {4'b0100, 4'h2, 1'b0})
            $display("FAIL loaded_single: got %b required %b",
                     {bus.Anode, bus.Hex, bus.Loaded}, {4'b0100, 4'h2, 1'b0});
        else passed++;
        step();
        step();
        step();
        checks++;
        if ({bus.Anode, bus.Hex} !== {4'b1000, 4'h1})
            $display("FAIL new_digit3: got %b required %b", {bus.Anode, bus.Hex}, {4'b1000, 4'h1});
        else passed++;
    endtask

    task automatic test_blank();
        int d;
        bus.DigitBlank = 4'b0100;
        for (int i = 0; i < 16; i++) begin
            step();
            d = (edge_no / 4) % 4;
            checks++;
            if ({bus.Anode, bus.Hex, bus.DP} !== {onehot(d), nib(16'h1234, d), (d == 2)})
                $display("FAIL digit_blank[%0d]: got %b required %b", i,
                         {bus.Anode, bus.Hex, bus.DP}, {onehot(d), nib(16'h1234, d), (d == 2)});
            else passed++;
        end
        bus.DigitBlank = 4'b0000;
    endtask

    task automatic test_lzb();
        int   d;
        logic exp_dp;
        bus.Load = 1'b1;
        bus.Value = 16'h0005;
        step();
        checks++;
        if (bus.Loaded !== 1'b1)
            $display("FAIL held_load_1: got %b required 1", bus.Loaded);
        else passed++;
        step();
        checks++;
        if (bus.Loaded !== 1'b1)
            $display("FAIL held_load_2: got %b required 1", bus.Loaded);
        else passed++;
        bus.Load = 1'b0;
        step();
        checks++;
        if (bus.Loaded !== 1'b0)
            $display("FAIL held_load_end: got %b required 0", bus.Loaded);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            step();
            d = (edge_no / 4) % 4;
`ifdef HEX_LZB_EN
            exp_dp = (d != 0);
`else
            exp_dp = 1'b0;
`endif
            checks++;
            if ({bus.Anode, bus.Hex, bus.DP} !== {onehot(d), nib(16'h0005, d), exp_dp})
                $display("FAIL lzb_0005[%0d]: got %b required %b", i,
                         {bus.Anode, bus.Hex, bus.DP}, {onehot(d), nib(16'h0005, d), exp_dp});
            else passed++;
        end
        bus.Load = 1'b1;
        bus.Value = 16'h0000;
        step();
        bus.Load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            d = (edge_no / 4) % 4;
`ifdef HEX_LZB_EN
            exp_dp = (d != 0);
`else
            exp_dp = 1'b0;
`endif
            checks++;
            if ({bus.Anode, bus.Hex, bus.DP} !== {onehot(d), 4'h0, exp_dp})
                $display("FAIL lzb_0000[%0d]: got %b required %b", i,
                         {bus.Anode, bus.Hex, bus.DP}, {onehot(d), 4'h0, exp_dp});
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        while ((edge_no % 16) != 9) step();
        checks++;
        if (bus.Anode !== 4'b0100)
            $display("FAIL pre_reset_digit2: got %b required 0100", bus.Anode);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.Anode, bus.DP, bus.Hex, bus.Loaded} !== {4'b0000, 1'b1, 4'h0, 1'b0})
            $display("FAIL async_reset_out: got %b required %b",
                     {bus.Anode, bus.DP, bus.Hex, bus.Loaded}, {4'b0000, 1'b1, 4'h0, 1'b0});
        else passed++;
        step();
        checks++;
        if ({bus.Anode, bus.DP, bus.Hex, bus.Loaded} !== {4'b0000, 1'b1, 4'h0, 1'b0})
            $display("FAIL reset_held: got %b required %b",
                     {bus.Anode, bus.DP, bus.Hex, bus.Loaded}, {4'b0000, 1'b1, 4'h0, 1'b0});
        else passed++;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({bus.Anode, bus.Hex, bus.DP} !== {4'b0001, 4'h0, 1'b0})
                $display("FAIL restart_digit0[%0d]: got %b required %b", k,
                         {bus.Anode, bus.Hex, bus.DP}, {4'b0001, 4'h0, 1'b0});
            else passed++;
        end
        step();
        checks++;
        if (bus.Anode !== 4'b0010)
            $display("FAIL restart_digit1: got %b required 0010", bus.Anode);
        else passed++;
    endtask

    task automatic test_idle_hold();
        step();
        bus.Enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus.Anode, bus.DP, bus.Hex} !== {4'b0000, 1'b1, 4'h0})
                $display("FAIL idle_hold[%0d]: got %b required %b", i,
                         {bus.Anode, bus.DP, bus.Hex}, {4'b0000, 1'b1, 4'h0});
            else passed++;
        end
        bus.Enable = 1'b1;
        step();
        checks++;
        if (bus.Anode !== 4'b0010)
            $display("FAIL resume_digit1: got %b required 0010", bus.Anode);
        else passed++;
        step();
        checks++;
        if (bus.Anode !== 4'b0010)
            $display("FAIL resume_count3: got %b required 0010", bus.Anode);
        else passed++;
        step();
        checks++;
        if (bus.Anode !== 4'b0100)
            $display("FAIL resume_advance: got %b required 0100", bus.Anode);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_tick();
        test_blank();
        test_lzb();
        test_reset_mid();
        test_idle_hold();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
